// File: rtl/cnn_layer_accel_job_pkg.sv
// rtl/cnn_layer_accel_job_pkg.sv - shared types and field layout for the job controller
package cnn_layer_accel_job_pkg;

    localparam int C_CNT_WIDTH_DEFAULT = 24;

    localparam int PIX_LSB = 0;
    localparam int PIX_MSB = 23;
    localparam int WT_LSB  = 24;
    localparam int WT_MSB  = 47;
    localparam int RES_LSB = 48;
    localparam int RES_MSB = 71;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACCEPT,
        ST_FETCH_REQ,
        ST_FETCH,
        ST_FETCH_DONE,
        ST_RUN,
        ST_COMPLETE
    } job_state_t;

endpackage

// File: rtl/cnn_layer_accel_beat_counter.sv
// rtl/cnn_layer_accel_beat_counter.sv - loadable beat counter with equality done flag
module cnn_layer_accel_beat_counter
    import cnn_layer_accel_job_pkg::*;
#(
    parameter int C_CNT_WIDTH = C_CNT_WIDTH_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   load,
    input  logic [C_CNT_WIDTH-1:0] total,
    input  logic                   fire,
    input  logic                   clear,
    output logic [C_CNT_WIDTH-1:0] count,
    output logic                   done,
    output logic                   last
);

    localparam logic [C_CNT_WIDTH-1:0] ONE = C_CNT_WIDTH'(1);

    logic [C_CNT_WIDTH-1:0] total_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count   <= '0;
            total_q <= '0;
        end else if (clear) begin
            count   <= '0;
            total_q <= '0;
        end else if (load) begin
            count   <= '0;
            total_q <= total;
        end else if (fire) begin
            count   <= count + ONE;
        end
    end

    // fire is gated by !done upstream, so count+1 never wraps past total
    assign done = (count == total_q);
    assign last = fire && ((count + ONE) == total_q);

endmodule

// File: rtl/cnn_layer_accel_job_ctrl.sv
// rtl/cnn_layer_accel_job_ctrl.sv - host job protocol responder with stream gating and beat counting
module cnn_layer_accel_job_ctrl
    import cnn_layer_accel_job_pkg::*;
#(
    parameter int C_CNT_WIDTH = C_CNT_WIDTH_DEFAULT
) (
    input  logic         clk_if,
    input  logic         rst_n,
    input  logic         job_start,
    output logic         job_accept,
    input  logic [127:0] job_parameters,
    output logic         job_fetch_request,
    input  logic         job_fetch_ack,
    output logic         job_fetch_complete,
    output logic         job_complete,
    input  logic         job_complete_ack,
    input  logic         pixel_valid,
    output logic         pixel_ready,
    input  logic         pixel_sink_ready,
    input  logic         weight_valid,
    output logic         weight_ready,
    input  logic         weight_sink_ready,
    input  logic         result_valid,
    input  logic         result_accept,
    output logic         busy
);

    job_state_t state, next_state;

    logic load, clear;
    logic pix_fire, wt_fire, res_fire, res_window;
    logic pix_done, wt_done, res_done;
    logic pix_last, wt_last, res_last;
    logic [C_CNT_WIDTH-1:0] pix_count, wt_count, res_count;
    logic unused_bits;

    assign load  = (state == ST_IDLE) && job_start;
    assign clear = (state == ST_COMPLETE) && job_complete_ack;

    assign pixel_ready  = (state == ST_FETCH) && pixel_sink_ready && !pix_done;
    assign weight_ready = (state == ST_FETCH) && weight_sink_ready && !wt_done;

    assign pix_fire = pixel_valid && pixel_ready;
    assign wt_fire  = weight_valid && weight_ready;

    // results may arrive as soon as streaming begins
    assign res_window = (state == ST_FETCH) || (state == ST_FETCH_DONE) || (state == ST_RUN);
    assign res_fire   = result_valid && result_accept && res_window && !res_done;

    assign unused_bits = ^{job_parameters[127:RES_MSB+1], pix_count, wt_count, res_count, res_last};

    cnn_layer_accel_beat_counter #(.C_CNT_WIDTH(C_CNT_WIDTH)) u_pix_cnt (
        .clk(clk_if), .rst_n(rst_n), .load(load),
        .total(C_CNT_WIDTH'(job_parameters[PIX_MSB:PIX_LSB])),
        .fire(pix_fire), .clear(clear), .count(pix_count), .done(pix_done), .last(pix_last)
    );

    cnn_layer_accel_beat_counter #(.C_CNT_WIDTH(C_CNT_WIDTH)) u_wt_cnt (
        .clk(clk_if), .rst_n(rst_n), .load(load),
        .total(C_CNT_WIDTH'(job_parameters[WT_MSB:WT_LSB])),
        .fire(wt_fire), .clear(clear), .count(wt_count), .done(wt_done), .last(wt_last)
    );

    cnn_layer_accel_beat_counter #(.C_CNT_WIDTH(C_CNT_WIDTH)) u_res_cnt (
        .clk(clk_if), .rst_n(rst_n), .load(load),
        .total(C_CNT_WIDTH'(job_parameters[RES_MSB:RES_LSB])),
        .fire(res_fire), .clear(clear), .count(res_count), .done(res_done), .last(res_last)
    );

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:       if (job_start) next_state = ST_ACCEPT;
            ST_ACCEPT:     next_state = ST_FETCH_REQ;
            ST_FETCH_REQ:  if (job_fetch_ack) next_state = (pix_done && wt_done) ? ST_FETCH_DONE : ST_FETCH;
            ST_FETCH:      if ((pix_done || pix_last) && (wt_done || wt_last)) next_state = ST_FETCH_DONE;
            ST_FETCH_DONE: next_state = ST_RUN;
            ST_RUN:        if (res_done) next_state = ST_COMPLETE;
            ST_COMPLETE:   if (job_complete_ack) next_state = ST_IDLE;
            default:       next_state = ST_IDLE;
        endcase
    end

    // handshake outputs are registered images of the state being entered
    always_ff @(posedge clk_if or negedge rst_n) begin
        if (!rst_n) begin
            state              <= ST_IDLE;
            job_accept         <= 1'b0;
            job_fetch_request  <= 1'b0;
            job_fetch_complete <= 1'b0;
            job_complete       <= 1'b0;
            busy               <= 1'b0;
        end else begin
            state              <= next_state;
            job_accept         <= (next_state == ST_ACCEPT);
            job_fetch_request  <= (next_state == ST_FETCH_REQ);
            job_fetch_complete <= (next_state == ST_FETCH_DONE);
            job_complete       <= (next_state == ST_COMPLETE);
            busy               <= (next_state != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_cnn_layer_accel_job_ctrl.sv
// tb/tb_cnn_layer_accel_job_ctrl.sv - self-checking bench for cnn_layer_accel_job_ctrl
module tb_cnn_layer_accel_job_ctrl;

    logic         clk_if = 1'b0;
    logic         rst_n = 1'b0;
    logic         job_start = 1'b0;
    logic         job_accept;
    logic [127:0] job_parameters = '0;
    logic         job_fetch_request;
    logic         job_fetch_ack = 1'b0;
    logic         job_fetch_complete;
    logic         job_complete;
    logic         job_complete_ack = 1'b0;
    logic         pixel_valid = 1'b0;
    logic         pixel_ready;
    logic         pixel_sink_ready = 1'b0;
    logic         weight_valid = 1'b0;
    logic         weight_ready;
    logic         weight_sink_ready = 1'b0;
    logic         result_valid = 1'b0;
    logic         result_accept = 1'b0;
    logic         busy;

    int checks = 0;
    int passes = 0;

    always #5 clk_if = ~clk_if;

    cnn_layer_accel_job_ctrl dut (
        .clk_if(clk_if), .rst_n(rst_n),
        .job_start(job_start), .job_accept(job_accept), .job_parameters(job_parameters),
        .job_fetch_request(job_fetch_request), .job_fetch_ack(job_fetch_ack),
        .job_fetch_complete(job_fetch_complete), .job_complete(job_complete),
        .job_complete_ack(job_complete_ack),
        .pixel_valid(pixel_valid), .pixel_ready(pixel_ready), .pixel_sink_ready(pixel_sink_ready),
        .weight_valid(weight_valid), .weight_ready(weight_ready), .weight_sink_ready(weight_sink_ready),
        .result_valid(result_valid), .result_accept(result_accept), .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk_if);
        #1;
    endtask

    task automatic idle_inputs();
        job_start = 1'b0; job_fetch_ack = 1'b0; job_complete_ack = 1'b0;
        pixel_valid = 1'b0; pixel_sink_ready = 1'b0;
        weight_valid = 1'b0; weight_sink_ready = 1'b0;
        result_valid = 1'b0; result_accept = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_accept"}, 32'(job_accept), 0);
        chk({tag, "_fetch_req"}, 32'(job_fetch_request), 0);
        chk({tag, "_fetch_cmp"}, 32'(job_fetch_complete), 0);
        chk({tag, "_complete"}, 32'(job_complete), 0);
        chk({tag, "_pix_ready"}, 32'(pixel_ready), 0);
        chk({tag, "_wt_ready"}, 32'(weight_ready), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
    endtask

    // Host model: drives one job from IDLE and predicts every handshake from the
    // protocol rules (beats accepted only while streaming and below the total).
    // sink_mode 0: back-to-back, ack after 2; 1: pixel sink toggles; 2: random.
    task automatic run_job(input int pix, input int wt, input int res, input int sink_mode,
                           input bit hold, input bit spurious, input int abort_pix);
        int  ack_delay, cack_delay, comp_c;
        int  pix_acc, wt_acc, res_acc, dut_pix, dut_wt, accepts;
        bit  ack_done, ack_now, fc_due, fc_flag, fc_seen, done, aborted;
        bit  exp_pr, exp_wr;
        logic [127:0] params;

        ack_delay = (sink_mode == 0) ? 2 : int'($urandom_range(0, 3));
        cack_delay = 0; comp_c = -1;
        pix_acc = 0; wt_acc = 0; res_acc = 0; dut_pix = 0; dut_wt = 0; accepts = 0;
        ack_done = 0; fc_due = 0; fc_flag = 0; fc_seen = 0; done = 0; aborted = 0;

        params = {$urandom, $urandom, $urandom, $urandom};
        params[23:0]  = pix[23:0];
        params[47:24] = wt[23:0];
        params[71:48] = res[23:0];
        job_parameters = params;

        if (spurious) begin
            job_fetch_ack = 1'b1;
            step();
            job_fetch_ack = 1'b0;
            chk("spur_fack_busy", 32'(busy), 0);
            chk("spur_fack_req", 32'(job_fetch_request), 0);
        end

        for (int c = 0; c < 400 && !done; c++) begin
            chk("accept", 32'(job_accept), 32'(c == 1));
            if (job_accept) accepts++;
            chk("fetch_req", 32'(job_fetch_request), 32'(c >= 2 && !ack_done));
            chk("fetch_complete", 32'(job_fetch_complete), 32'(fc_due));
            if (fc_due) fc_seen = 1;
            fc_due = 0;
            chk("busy", 32'(busy), 32'(c >= 1));
            if (comp_c >= 0) begin
                chk("complete_held", 32'(job_complete), 1);
            end else if (job_complete) begin
                chk("complete_gate", 32'({fc_seen, res_acc == res}), 3);
                comp_c = c;
                cack_delay = int'($urandom_range(0, 3));
            end

            job_start = (c == 0) || hold;
            ack_now = (c == 2 + ack_delay);
            job_fetch_ack = ack_now;
            case (sink_mode)
                0: begin pixel_sink_ready = 1'b1; weight_sink_ready = 1'b1; end
                1: begin pixel_sink_ready = c[0]; weight_sink_ready = 1'b1; end
                default: begin
                    pixel_sink_ready  = ($urandom_range(0, 1) == 1);
                    weight_sink_ready = ($urandom_range(0, 1) == 1);
                end
            endcase
            pixel_valid  = (sink_mode == 0) || ($urandom_range(0, 3) != 0);
            weight_valid = (sink_mode == 0) || ($urandom_range(0, 3) != 0);
            result_valid  = ack_done && (res_acc < res) && ($urandom_range(0, 2) != 0);
            result_accept = ack_done && (res_acc < res) && ($urandom_range(0, 2) != 0);
            job_complete_ack = (comp_c >= 0 && c >= comp_c + cack_delay) ||
                               (spurious && comp_c < 0 && ack_done && c[0]);

            @(negedge clk_if);
            exp_pr = ack_done && pixel_sink_ready && (pix_acc < pix);
            exp_wr = ack_done && weight_sink_ready && (wt_acc < wt);
            chk("pixel_ready", 32'(pixel_ready), 32'(exp_pr));
            chk("weight_ready", 32'(weight_ready), 32'(exp_wr));
            if (pixel_valid && pixel_ready) dut_pix++;
            if (weight_valid && weight_ready) dut_wt++;
            if (pixel_valid && exp_pr) pix_acc++;
            if (weight_valid && exp_wr) wt_acc++;
            if (result_valid && result_accept) res_acc++;
            if ((ack_done || ack_now) && !fc_flag && pix_acc == pix && wt_acc == wt) begin
                fc_flag = 1;
                fc_due = 1;
            end
            ack_done = ack_done || ack_now;
            if (job_complete_ack && comp_c >= 0) done = 1;
            step();
            if (abort_pix > 0 && pix_acc == abort_pix) begin
                aborted = 1;
                break;
            end
        end

        if (!aborted) begin
            chk("job_finished", 32'(done), 1);
            chk("accept_pulses", 32'(accepts), 1);
            chk("pix_beats", 32'(dut_pix), 32'(pix));
            chk("wt_beats", 32'(dut_wt), 32'(wt));
            chk("fc_seen", 32'(fc_seen), 1);
            chk("complete_drop", 32'(job_complete), 0);
            chk("busy_end", 32'(busy), 0);
        end else begin
            chk("abort_beats", 32'(dut_pix), 32'(abort_pix));
        end
        job_fetch_ack = 1'b0;
        job_complete_ack = 1'b0;
        result_valid = 1'b0;
        result_accept = 1'b0;
        if (!hold) job_start = 1'b0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        #1;
        check_all_zero("rst");
        step();
        step();
        idle_inputs();
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        int gap;

        idle_inputs();
        #2;
        check_all_zero("por");
        step();
        step();
        rst_n = 1'b1;
        step();
        check_all_zero("idle");

        run_job(4, 2, 3, 0, 0, 0, 0);
        run_job(6, 0, 1, 1, 0, 0, 0);
        run_job(0, 0, 0, 2, 0, 0, 0);

        run_job(3, 3, 2, 2, 1, 0, 0);
        gap = -1;
        for (int g = 1; g <= 6; g++) begin
            if (job_accept) begin
                gap = g;
                break;
            end
            step();
        end
        chk("rearm_gap_ok", 32'(gap >= 2 && gap <= 6), 1);
        job_start = 1'b0;
        apply_reset();

        run_job(8, 0, 0, 0, 0, 0, 3);
        pixel_valid = 1'b1;
        pixel_sink_ready = 1'b1;
        apply_reset();
        run_job(2, 0, 0, 2, 0, 0, 0);

        run_job(2, 3, 2, 2, 0, 1, 0);

        for (int j = 0; j < 6; j++) begin
            run_job(int'($urandom_range(0, 5)), int'($urandom_range(0, 5)),
                    int'($urandom_range(0, 4)), int'($urandom_range(0, 2)), 0, ($urandom_range(0, 1) == 1), 0);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/cnn_layer_accel_job_ctrl.md
Name: cnn_layer_accel_job_ctrl

Overview:
- Quad-side responder for the host job protocol. The host issues job_start, job_fetch_ack and job_complete_ack; this block answers with job_accept, job_fetch_request, job_fetch_complete and job_complete.
- Gates pixel/weight stream readiness during the fetch phase, counts stream beats, and snoops the result handshake to detect job end.
- Sits between the host interface and the quad datapath, in the clk_if domain.

Parameters:
- C_CNT_WIDTH, 24, width of each beat/result counter and of each job_parameters count field.

Ports:
- clk_if  input  1  interface clock
- rst_n  input  1  asynchronous active-low reset
- job_start  input  1  host requests a new job (level, sampled in IDLE)
- job_accept  output  1  one-cycle pulse: job latched
- job_parameters  input  128  [23:0] pixel beats, [47:24] weight beats, [71:48] result count, [127:72] reserved/ignored
- job_fetch_request  output  1  request host to stream data
- job_fetch_ack  input  1  host acknowledges fetch request
- job_fetch_complete  output  1  one-cycle pulse: all pixel and weight beats received
- job_complete  output  1  held until acknowledged
- job_complete_ack  input  1  host acknowledges completion
- pixel_valid  input  1  host pixel beat valid
- pixel_ready  output  1  pixel beat accepted when valid&ready
- pixel_sink_ready  input  1  datapath pixel buffer can accept
- weight_valid  input  1  host weight beat valid
- weight_ready  output  1  weight beat accepted when valid&ready
- weight_sink_ready  input  1  datapath weight buffer can accept
- result_valid  input  1  snooped result handshake
- result_accept  input  1  snooped result handshake
- busy  output  1  state != IDLE

Behaviour:
- Reset (rst_n low, async): state=IDLE, all counters 0, and every output 0. Deassertion is synchronised by the parent.
- States: IDLE, ACCEPT, FETCH_REQ, FETCH, FETCH_DONE, RUN, COMPLETE.
- IDLE:
  - job_start=1 -> latch the three count fields, go to ACCEPT.
  - job_accept rises the cycle after job_start is sampled.
- ACCEPT:
  - job_accept=1 for exactly one cycle, then FETCH_REQ.
- FETCH_REQ:
  - job_fetch_request=1, held until a cycle with job_fetch_ack=1.
  - On that cycle the request drops next cycle and the state moves to FETCH.
  - If both pixel and weight counts are 0, go straight to FETCH_DONE instead.
- FETCH:
  - pixel_ready = pixel_sink_ready & (pix_cnt != pix_total).
  - weight_ready = weight_sink_ready & (wt_cnt != wt_total).
  - Both ready signals are combinational and 0 in every other state.
  - Each counter increments on its own valid&ready.
  - Pixel and weight beats in the same cycle are both counted.
  - When both counters reach their totals (including on the final beat cycle), go to FETCH_DONE next cycle.
- FETCH_DONE:
  - job_fetch_complete=1 for one cycle, then RUN.
- RUN:
  - res_cnt increments on result_valid&result_accept; result handshakes are also counted in FETCH and FETCH_DONE.
  - When res_cnt == res_total, go to COMPLETE.
  - A result total of 0 passes through RUN in one cycle.
- COMPLETE:
  - job_complete=1 until a cycle with job_complete_ack=1.
  - That cycle: output drops next cycle, counters clear, state returns to IDLE.
  - A new job_start is sampled in IDLE no earlier than the following cycle.
- Ignored inputs:
  - job_start outside IDLE.
  - job_fetch_ack outside FETCH_REQ.
  - job_complete_ack outside COMPLETE.
  - Beats offered beyond a count are not accepted (ready low).
- Counters: C_CNT_WIDTH bits, compared for equality only, never wrap. The maximum count 2^C_CNT_WIDTH-1 is legal.
- Registered outputs: job_accept, job_fetch_request, job_fetch_complete, job_complete, busy. Ready signals are combinational as above.
- Reset mid-job: immediate return to IDLE. No partial completion is signalled.

Decomposition:
- Shared package cnn_layer_accel_job_pkg holds:
  - the state enum job_state_t;
  - the job_parameters field LSB/MSB constants;
  - C_CNT_WIDTH default.
- One natural sub-module: cnn_layer_accel_beat_counter. It provides count, total, fire, done and clear, and is instantiated three times (pixel, weight, result).

Test Plan:
- Counts pix=4, wt=2, res=3; host acks after 2 cycles and streams back-to-back:
  - job_accept pulses once;
  - exactly 4 pixel and 2 weight beats accepted; a 5th offered pixel sees pixel_ready=0;
  - job_fetch_complete pulses once;
  - after 3 result handshakes, job_complete stays high until ack, then busy=0.
- pixel_sink_ready toggling every other cycle, pix=6: exactly 6 beats accepted, never while sink_ready=0; fetch_complete follows the last beat by 1 cycle.
- Counts all 0: the sequence accept -> fetch_request -> ack -> fetch_complete -> complete runs with no ready ever asserted.
- job_start held high through a whole job plus 5 cycles after ack: exactly two job_accept pulses, the second no earlier than 2 cycles after job_complete_ack.
- rst_n asserted mid-FETCH after 3 of 8 pixels: all outputs 0 immediately. After release, a new job pix=2 completes with a count of exactly 2.
- Spurious job_fetch_ack in IDLE and job_complete_ack in RUN: no state change, and the job still completes normally.
